// File: rtl/alu_cmd_issuer.sv
// Issues valid/ready ALU commands to a combinational ALU, holds operands ALU_LATENCY cycles, returns result.
// Latency: ALU_LATENCY+1 cycles for legal codes, 1 for illegal codes; cmd_ready stalls while a response waits on rsp_ready.
module alu_cmd_issuer #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [5:0]       cmd_funct,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_dataA,
  output logic [31:0]      alu_dataB,
  output logic [5:0]       alu_Signal,
  output logic             alu_reset,
  input  logic [31:0]      alu_dataOut,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int unsigned CNT_W = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  generate
    if (ALU_LATENCY < 1) begin : g_bad_latency
      $error("alu_cmd_issuer: ALU_LATENCY must be at least 1");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        data_a_q, data_a_d;
  logic [31:0]        data_b_q, data_b_d;
  logic [5:0]         signal_q, signal_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_err_q, rsp_err_d;
  logic [15:0]        op_count_q, op_count_d;
  logic               accept;
  logic               funct_ok;

  always_comb begin
    funct_ok = 1'b0;
    case (cmd_funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
      default:                               funct_ok = 1'b0;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    signal_d   = signal_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    op_count_d = op_count_q;

    case (state_q)
      ST_HOLD: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d = alu_dataOut;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: ;
    endcase

    // A new accept overrides the RESP->IDLE transition so commands can stream back-to-back.
    if (accept) begin
      data_a_d  = cmd_a;
      data_b_d  = cmd_b;
      signal_d  = cmd_funct;
      rsp_tag_d = cmd_tag;
      if (funct_ok) begin
        cnt_d   = CNT_W'(ALU_LATENCY);
        state_d = ST_HOLD;
      end else begin
        rsp_data_d = 32'd0;
        rsp_err_d  = 1'b1;
        state_d    = ST_RESP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_a_q   <= 32'd0;
      data_b_q   <= 32'd0;
      signal_q   <= 6'd0;
      rsp_data_q <= 32'd0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
      op_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      signal_q   <= signal_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
      op_count_q <= op_count_d;
    end
  end

  assign alu_dataA  = data_a_q;
  assign alu_dataB  = data_b_q;
  assign alu_Signal = signal_q;
  assign alu_reset  = (state_q != ST_HOLD);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != ST_IDLE);
  assign op_count   = op_count_q;

  // A stalled response must not change underneath the consumer.
  a_rsp_stable: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_tag) && $stable(rsp_err)));

  a_hold_cnt: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_HOLD) |-> (cnt_q != '0));

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: two instances (ALU_LATENCY 1 and 3) behind a shared driver, random and directed
// commands checked against a behavioural ALU/issuer model.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        use3;
  logic        cmd_valid, rsp_ready;
  logic [5:0]  cmd_funct;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_tag;

  int total = 0;
  int bad   = 0;
  int exp_ops [2];

  always #5 clk = ~clk;

  // Reference ALU: {err, data}; err set for any code outside the five supported ones.
  function automatic logic [32:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      6'b100000: return {1'b0, a + b};
      6'b100010: return {1'b0, a - b};
      6'b100100: return {1'b0, a & b};
      6'b100101: return {1'b0, a | b};
      6'b101010: return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
      default:   return {1'b1, 32'd0};
    endcase
  endfunction

  logic        cv1, cr1, ar1, rv1, re1, bz1;
  logic        cv3, cr3, ar3, rv3, re3, bz3;
  logic [31:0] da1, db1, do1, rd1, da3, db3, do3, rd3;
  logic [5:0]  sg1, sg3;
  logic [3:0]  rt1, rt3;
  logic [15:0] oc1, oc3;
  logic [32:0] r1, r3;

  assign cv1 = cmd_valid & ~use3;
  assign cv3 = cmd_valid & use3;
  assign r1  = ref_op(sg1, da1, db1);
  assign r3  = ref_op(sg3, da3, db3);
  // Environment ALU: forced to zero under alu_reset, garbage for unsupported codes.
  assign do1 = ar1 ? 32'd0 : (r1[32] ? 32'hDEADBEEF : r1[31:0]);
  assign do3 = ar3 ? 32'd0 : (r3[32] ? 32'hDEADBEEF : r3[31:0]);

  alu_cmd_issuer #(.ALU_LATENCY(1), .TAG_W(4)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cv1), .cmd_ready(cr1), .cmd_funct(cmd_funct),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag), .alu_dataA(da1), .alu_dataB(db1),
    .alu_Signal(sg1), .alu_reset(ar1), .alu_dataOut(do1), .rsp_valid(rv1), .rsp_ready(rsp_ready),
    .rsp_data(rd1), .rsp_tag(rt1), .rsp_err(re1), .busy(bz1), .op_count(oc1));

  alu_cmd_issuer #(.ALU_LATENCY(3), .TAG_W(4)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cv3), .cmd_ready(cr3), .cmd_funct(cmd_funct),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag), .alu_dataA(da3), .alu_dataB(db3),
    .alu_Signal(sg3), .alu_reset(ar3), .alu_dataOut(do3), .rsp_valid(rv3), .rsp_ready(rsp_ready),
    .rsp_data(rd3), .rsp_tag(rt3), .rsp_err(re3), .busy(bz3), .op_count(oc3));

  logic        o_cmd_ready, o_alu_reset, o_rsp_valid, o_rsp_err, o_busy;
  logic [31:0] o_alu_dataA, o_alu_dataB, o_rsp_data;
  logic [5:0]  o_alu_Signal;
  logic [3:0]  o_rsp_tag;
  logic [15:0] o_op_count;

  assign o_cmd_ready  = use3 ? cr3 : cr1;
  assign o_alu_reset  = use3 ? ar3 : ar1;
  assign o_rsp_valid  = use3 ? rv3 : rv1;
  assign o_rsp_err    = use3 ? re3 : re1;
  assign o_busy       = use3 ? bz3 : bz1;
  assign o_alu_dataA  = use3 ? da3 : da1;
  assign o_alu_dataB  = use3 ? db3 : db1;
  assign o_rsp_data   = use3 ? rd3 : rd1;
  assign o_alu_Signal = use3 ? sg3 : sg1;
  assign o_rsp_tag    = use3 ? rt3 : rt1;
  assign o_op_count   = use3 ? oc3 : oc1;

  // Drives one command, observes it, then completes the response handshake.
  task automatic run_cmd(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                         output int lat, output logic [31:0] d, output logic [3:0] tg, output logic e,
                         output int low, output logic [31:0] la, output logic [31:0] lb, output logic [5:0] ls);
    int n;
    @(negedge clk);
    cmd_funct = f; cmd_a = a; cmd_b = b; cmd_tag = t; cmd_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!o_cmd_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_funct = 6'($urandom); cmd_a = $urandom; cmd_b = $urandom; cmd_tag = 4'($urandom);
    la = o_alu_dataA; lb = o_alu_dataB; ls = o_alu_Signal;
    lat = 1; low = 0;
    while (!o_rsp_valid && lat < 40) begin
      if (!o_alu_reset) low++;
      @(negedge clk); lat++;
    end
    d = o_rsp_data; tg = o_rsp_tag; e = o_rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; use3 = 1'b0;
    cmd_funct = 6'd0; cmd_a = 32'd0; cmd_b = 32'd0; cmd_tag = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      use3 = s[0]; #1;
      total++; if ({o_alu_dataA, o_alu_dataB, o_alu_Signal} !== 70'd0) begin bad++; $display("FAIL reset_alu_regs got=%h exp=0", {o_alu_dataA, o_alu_dataB, o_alu_Signal}); end
      total++; if (o_alu_reset !== 1'b1) begin bad++; $display("FAIL reset_alu_reset got=%b exp=1", o_alu_reset); end
      total++; if ({o_rsp_valid, o_rsp_data, o_rsp_tag, o_rsp_err} !== 38'd0) begin bad++; $display("FAIL reset_rsp got=%h exp=0", {o_rsp_valid, o_rsp_data, o_rsp_tag, o_rsp_err}); end
      total++; if ({o_busy, o_op_count} !== 17'd0) begin bad++; $display("FAIL reset_busy_count got=%h exp=0", {o_busy, o_op_count}); end
      total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", o_cmd_ready); end
    end
    use3 = 1'b0;
    exp_ops[0] = 0; exp_ops[1] = 0;
  endtask

  task automatic test_directed();
    logic [5:0]  tf [8] = '{6'b100000, 6'b100010, 6'b101010, 6'b101010, 6'b101010, 6'b100100, 6'b100101, 6'b000000};
    logic [31:0] ta [8] = '{32'd5, 32'd3, 32'd3, 32'd5, 32'h80000000, 32'hF0F0, 32'hF0F0, 32'd9};
    logic [31:0] tb [8] = '{32'd7, 32'd5, 32'd5, 32'd3, 32'd1, 32'h0FF0, 32'h0FF0, 32'd4};
    logic [31:0] td [8] = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0, 32'd1, 32'h00F0, 32'hFFF0, 32'd0};
    int lat, low; logic [31:0] d, la, lb; logic [3:0] tg; logic e; logic [5:0] ls;
    use3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] t;
      logic       ee;
      t  = (i == 0) ? 4'd3 : 4'(i + 8);
      ee = (i == 7);
      run_cmd(tf[i], ta[i], tb[i], t, lat, d, tg, e, low, la, lb, ls);
      exp_ops[0]++;
      total++; if (d !== td[i]) begin bad++; $display("FAIL dir%0d_data got=%h exp=%h", i, d, td[i]); end
      total++; if ({tg, e} !== {t, ee}) begin bad++; $display("FAIL dir%0d_tag_err got=%h/%b exp=%h/%b", i, tg, e, t, ee); end
      total++; if (lat !== (ee ? 1 : 2)) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, ee ? 1 : 2); end
      total++; if (low !== (ee ? 0 : 1)) begin bad++; $display("FAIL dir%0d_alu_release got=%0d exp=%0d", i, low, ee ? 0 : 1); end
      total++; if ({la, lb, ls} !== {ta[i], tb[i], tf[i]}) begin bad++; $display("FAIL dir%0d_alu_inputs got=%h exp=%h", i, {la, lb, ls}, {ta[i], tb[i], tf[i]}); end
      total++; if (o_op_count !== 16'(exp_ops[0])) begin bad++; $display("FAIL dir%0d_op_count got=%0d exp=%0d", i, o_op_count, exp_ops[0]); end
    end
  endtask

  task automatic test_random(input logic sel, input int iters);
    logic [5:0]  legal [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [31:0] edges [4] = '{32'h80000000, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF};
    int lat, low, elat, lcy; logic [31:0] d, la, lb, a, b; logic [3:0] tg, t; logic e; logic [5:0] ls, f;
    logic [32:0] ex;
    use3 = sel;
    lcy  = sel ? 3 : 1;
    for (int i = 0; i < iters; i++) begin
      int k;
      k = $urandom_range(0, 6);
      f = (k < 5) ? legal[k] : 6'($urandom);
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      t = 4'($urandom);
      ex = ref_op(f, a, b);
      elat = ex[32] ? 1 : lcy + 1;
      run_cmd(f, a, b, t, lat, d, tg, e, low, la, lb, ls);
      exp_ops[sel]++;
      total++; if ({e, d} !== ex) begin bad++; $display("FAIL rnd%0d_%0d_result f=%b a=%h b=%h got=%h exp=%h", sel, i, f, a, b, {e, d}, ex); end
      total++; if (tg !== t) begin bad++; $display("FAIL rnd%0d_%0d_tag got=%h exp=%h", sel, i, tg, t); end
      total++; if (lat !== elat || low !== elat - 1) begin bad++; $display("FAIL rnd%0d_%0d_timing got=%0d/%0d exp=%0d/%0d", sel, i, lat, low, elat, elat - 1); end
      total++; if (o_op_count !== 16'(exp_ops[sel])) begin bad++; $display("FAIL rnd%0d_%0d_op_count got=%0d exp=%0d", sel, i, o_op_count, exp_ops[sel]); end
    end
    use3 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n; logic [37:0] held;
    use3 = 1'b0;
    @(negedge clk);
    cmd_funct = 6'b100000; cmd_a = 32'd10; cmd_b = 32'd20; cmd_tag = 4'd9; cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!o_rsp_valid && n < 20) begin @(negedge clk); n++; end
    cmd_funct = 6'b100010; cmd_a = 32'd100; cmd_b = 32'd1; cmd_tag = 4'd5; cmd_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      held = {o_rsp_valid, o_rsp_data, o_rsp_tag, o_rsp_err};
      total++; if ({held, o_cmd_ready} !== {1'b1, 32'd30, 4'd9, 1'b0, 1'b0}) begin bad++; $display("FAIL stall%0d got=%h exp=%h", c, {held, o_cmd_ready}, {1'b1, 32'd30, 4'd9, 1'b0, 1'b0}); end
      @(negedge clk);
    end
    rsp_ready = 1'b1; #1;
    total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_cmd_ready got=%b exp=1", o_cmd_ready); end
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    exp_ops[0]++;
    total++; if (o_op_count !== 16'(exp_ops[0])) begin bad++; $display("FAIL b2b_op_count got=%0d exp=%0d", o_op_count, exp_ops[0]); end
    total++; if ({o_alu_dataA, o_alu_Signal, o_rsp_tag, o_rsp_valid, o_busy} !== {32'd100, 6'b100010, 4'd5, 1'b0, 1'b1}) begin
      bad++; $display("FAIL b2b_accept got=%h exp=%h", {o_alu_dataA, o_alu_Signal, o_rsp_tag, o_rsp_valid, o_busy}, {32'd100, 6'b100010, 4'd5, 1'b0, 1'b1});
    end
    n = 0;
    while (!o_rsp_valid && n < 20) begin @(negedge clk); n++; end
    total++; if ({o_rsp_data, o_rsp_err} !== {32'd99, 1'b0}) begin bad++; $display("FAIL b2b_second_rsp got=%h exp=%h", {o_rsp_data, o_rsp_err}, {32'd99, 1'b0}); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops[0]++;
    total++; if (o_op_count !== 16'(exp_ops[0])) begin bad++; $display("FAIL b2b_op_count2 got=%0d exp=%0d", o_op_count, exp_ops[0]); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    use3 = 1'b1;
    @(negedge clk);
    cmd_funct = 6'b100000; cmd_a = 32'd1; cmd_b = 32'd2; cmd_tag = 4'd1; cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    total++; if ({o_busy, o_alu_reset} !== 2'b10) begin bad++; $display("FAIL midrst_in_hold got=%b exp=10", {o_busy, o_alu_reset}); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_ops[0] = 0; exp_ops[1] = 0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen |= o_rsp_valid;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_rsp got=%b exp=0", seen); end
    total++; if ({o_op_count, o_alu_reset, o_cmd_ready, o_busy} !== {16'd0, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL midrst_state got=%h exp=%h", {o_op_count, o_alu_reset, o_cmd_ready, o_busy}, {16'd0, 1'b1, 1'b1, 1'b0});
    end
    rsp_ready = 1'b0;
    use3 = 1'b0;
  endtask

  task automatic test_latency3();
    int lat, low; logic [31:0] d, la, lb; logic [3:0] tg; logic e; logic [5:0] ls;
    use3 = 1'b1;
    run_cmd(6'b100000, 32'd1, 32'd1, 4'd7, lat, d, tg, e, low, la, lb, ls);
    exp_ops[1]++;
    total++; if (lat !== 4) begin bad++; $display("FAIL lat3_latency got=%0d exp=4", lat); end
    total++; if (low !== 3) begin bad++; $display("FAIL lat3_hold_cycles got=%0d exp=3", low); end
    total++; if ({d, tg, e} !== {32'd2, 4'd7, 1'b0}) begin bad++; $display("FAIL lat3_rsp got=%h exp=%h", {d, tg, e}, {32'd2, 4'd7, 1'b0}); end
    test_random(1'b1, 20);
  endtask

  task automatic test_wrap();
    use3 = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    cmd_funct = 6'b000000; cmd_a = 32'd0; cmd_b = 32'd0; cmd_tag = 4'd2; cmd_valid = 1'b1; rsp_ready = 1'b1;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    total++; if ({o_op_count, o_rsp_valid, o_rsp_err} !== {16'hFFFF, 1'b1, 1'b1}) begin
      bad++; $display("FAIL wrap_before got=%h exp=%h", {o_op_count, o_rsp_valid, o_rsp_err}, {16'hFFFF, 1'b1, 1'b1});
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    total++; if ({o_op_count, o_rsp_valid} !== {16'd0, 1'b0}) begin bad++; $display("FAIL wrap_after got=%h exp=%h", {o_op_count, o_rsp_valid}, {16'd0, 1'b0}); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(1'b0, 40);
    test_back_to_back();
    test_reset_mid();
    test_latency3();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
